// File: rtl/flash_arb_pkg.sv
// Shared types and defaults for the flash access arbiter.
// Holds the FSM encoding, the default timing parameters and a saturating-increment helper.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant0 = 2'd1,
    StGrant1 = 2'd2,
    StDrain  = 2'd3
  } arb_state_e;

  localparam int unsigned DefSwitchGap     = 4;
  localparam int unsigned DefTimeoutCycles = 65535;
  localparam int unsigned CntW             = 17;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way round-robin picker for the flash arbiter.
// Tracks which requester was granted last; on a tie the other requester wins.
module flash_arb_rr (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic elig0,
  input  logic elig1,
  output logic pick0,
  output logic pick1
);

  logic last_q, last_d;

  always_comb begin
    pick0  = en & elig0 & (~elig1 | last_q);
    pick1  = en & elig1 & (~elig0 | ~last_q);
    last_d = last_q;
    if (pick0) begin
      last_d = 1'b0;
    end else if (pick1) begin
      last_d = 1'b1;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/flash_access_arbiter.sv
// Arbitrates the flash engine between the playback/record controller (r0) and the host port (r1),
// with a forced-revocation watchdog and a mode-switch gap before the next owner.
module flash_access_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned SWITCH_GAP     = DefSwitchGap,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_req,
  input  logic       r0_wren,
  input  logic       r0_rden,
  input  logic [7:0] r0_data,
  input  logic       r0_latch,
  input  logic       r0_continue,
  output logic       r0_grant,
  output logic       r0_ready,
  input  logic       r1_req,
  input  logic       r1_wren,
  input  logic       r1_rden,
  input  logic [7:0] r1_data,
  input  logic       r1_latch,
  input  logic       r1_continue,
  output logic       r1_grant,
  output logic       r1_ready,
  output logic [7:0] f_data,
  output logic       f_latch,
  output logic       f_continue,
  output logic       f_wren,
  output logic       f_rden,
  input  logic       f_ready,
  output logic       timeout_pulse
);

  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] GapVal     = CntW'(SWITCH_GAP);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] idle_q, idle_d;
  logic [CntW-1:0] gap_q, gap_d;
  logic            block0_q, block0_d, block1_q, block1_d;
  logic            r0_grant_q, r1_grant_q;
  logic            timeout_q, timeout_d;
  logic            arb_en, pick0, pick1;
  logic            in_grant, idle_hit, gap_done;

  assign arb_en   = (state_q == StIdle);
  assign in_grant = (state_q == StGrant0) || (state_q == StGrant1);
  assign idle_hit = (idle_q == TimeoutVal);
  // gap_q counts DRAIN cycles including the current one.
  assign gap_done = (gap_q >= GapVal);

  flash_arb_rr u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .elig0 (r0_req & ~block0_q),
    .elig1 (r1_req & ~block1_q),
    .pick0 (pick0),
    .pick1 (pick1)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      r0_grant_q <= 1'b0;
      r1_grant_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r0_grant_q <= (state_d == StGrant0);
      r1_grant_q <= (state_d == StGrant1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick0) begin
          state_d = StGrant0;
        end else if (pick1) begin
          state_d = StGrant1;
        end
      end
      StGrant0: if (!r0_req || idle_hit) state_d = StDrain;
      StGrant1: if (!r1_req || idle_hit) state_d = StDrain;
      StDrain:  if (gap_done && f_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic: the flash side is only driven while a grant is held.
  always_comb begin
    f_data     = 8'h00;
    f_latch    = 1'b0;
    f_continue = 1'b0;
    f_wren     = 1'b0;
    f_rden     = 1'b0;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    unique case (state_q)
      StGrant0: begin
        f_data     = r0_data;
        f_latch    = r0_latch & f_ready;
        f_continue = r0_continue;
        f_wren     = r0_wren;
        f_rden     = r0_rden & ~r0_wren;
        r0_ready   = f_ready;
      end
      StGrant1: begin
        f_data     = r1_data;
        f_latch    = r1_latch & f_ready;
        f_continue = r1_continue;
        f_wren     = r1_wren;
        f_rden     = r1_rden & ~r1_wren;
        r1_ready   = f_ready;
      end
      default: ;
    endcase
  end

  // Watchdog, gap counter and block flags.
  always_comb begin
    timeout_d = 1'b0;
    block0_d  = block0_q & r0_req;
    block1_d  = block1_q & r1_req;
    if (state_q == StGrant0 && idle_hit) begin
      timeout_d = 1'b1;
      block0_d  = 1'b1;
    end
    if (state_q == StGrant1 && idle_hit) begin
      timeout_d = 1'b1;
      block1_d  = 1'b1;
    end

    if (pick0 || pick1) begin
      idle_d = '0;
    end else if (in_grant && f_latch) begin
      idle_d = '0;
    end else begin
      idle_d = sat_inc(idle_q);
    end

    // Preload 1 outside DRAIN so the first DRAIN cycle counts as one.
    if (state_q != StDrain) begin
      gap_d = CntW'(1);
    end else begin
      gap_d = sat_inc(gap_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q    <= '0;
      gap_q     <= '0;
      block0_q  <= 1'b0;
      block1_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      gap_q     <= gap_d;
      block0_q  <= block0_d;
      block1_q  <= block1_d;
      timeout_q <= timeout_d;
    end
  end

  assign r0_grant      = r0_grant_q;
  assign r1_grant      = r1_grant_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_flash_access_arbiter.sv
// Directed bench for flash_access_arbiter with SWITCH_GAP=4 and TIMEOUT_CYCLES=100.
module tb_flash_access_arbiter;
  import flash_arb_pkg::*;

  logic       clk;
  logic       rst;
  logic       r0_req, r0_wren, r0_rden, r0_latch, r0_continue;
  logic [7:0] r0_data;
  logic       r1_req, r1_wren, r1_rden, r1_latch, r1_continue;
  logic [7:0] r1_data;
  logic       r0_grant, r0_ready, r1_grant, r1_ready;
  logic [7:0] f_data;
  logic       f_latch, f_continue, f_wren, f_rden, f_ready, timeout_pulse;

  int checks = 0;
  int errors = 0;

  flash_access_arbiter #(
    .SWITCH_GAP     (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .r0_req        (r0_req),
    .r0_wren       (r0_wren),
    .r0_rden       (r0_rden),
    .r0_data       (r0_data),
    .r0_latch      (r0_latch),
    .r0_continue   (r0_continue),
    .r0_grant      (r0_grant),
    .r0_ready      (r0_ready),
    .r1_req        (r1_req),
    .r1_wren       (r1_wren),
    .r1_rden       (r1_rden),
    .r1_data       (r1_data),
    .r1_latch      (r1_latch),
    .r1_continue   (r1_continue),
    .r1_grant      (r1_grant),
    .r1_ready      (r1_ready),
    .f_data        (f_data),
    .f_latch       (f_latch),
    .f_continue    (f_continue),
    .f_wren        (f_wren),
    .f_rden        (f_rden),
    .f_ready       (f_ready),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r0_req = 0; r0_wren = 0; r0_rden = 0; r0_latch = 0; r0_continue = 0; r0_data = 8'h00;
    r1_req = 0; r1_wren = 0; r1_rden = 0; r1_latch = 0; r1_continue = 0; r1_data = 8'h00;
    f_ready = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    r0_req = 1; r0_wren = 1; r0_latch = 1; r0_data = 8'h5A;
    tick();
    tick();
    checks++; if (r0_grant !== 1'b0) begin errors++; $display("FAIL rst_r0_grant: got %b want 0", r0_grant); end
    checks++; if (r1_grant !== 1'b0) begin errors++; $display("FAIL rst_r1_grant: got %b want 0", r1_grant); end
    checks++; if ({f_wren, f_rden, f_latch, f_continue} !== 4'b0000) begin
      errors++; $display("FAIL rst_fctl: got %b want 0000", {f_wren, f_rden, f_latch, f_continue});
    end
    checks++; if (f_data !== 8'h00) begin errors++; $display("FAIL rst_fdata: got %h want 00", f_data); end
    checks++; if ({r0_ready, r1_ready, timeout_pulse} !== 3'b000) begin
      errors++; $display("FAIL rst_ready_to: got %b want 000", {r0_ready, r1_ready, timeout_pulse});
    end
    checks++; if (dut.state_q !== StIdle) begin errors++; $display("FAIL rst_state: got %0d want 0", dut.state_q); end
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_single_grant();
    do_reset();
    r0_req = 1; r0_wren = 1;
    tick();
    checks++; if (r0_grant !== 1'b1) begin errors++; $display("FAIL single_grant: got %b want 1", r0_grant); end
    checks++; if (r1_grant !== 1'b0) begin errors++; $display("FAIL single_other: got %b want 0", r1_grant); end
    checks++; if ({r0_ready, r1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready: got %b want 10", {r0_ready, r1_ready});
    end
    r0_data = 8'hA5; r0_latch = 1; r0_continue = 1;
    #1;
    checks++; if (f_latch !== 1'b1) begin errors++; $display("FAIL single_latch: got %b want 1", f_latch); end
    checks++; if (f_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", f_data); end
    checks++; if (f_continue !== 1'b1) begin errors++; $display("FAIL single_cont: got %b want 1", f_continue); end
    f_ready = 0;
    #1;
    checks++; if ({f_latch, r0_ready} !== 2'b00) begin
      errors++; $display("FAIL single_notready: got %b want 00", {f_latch, r0_ready});
    end
    f_ready = 1; r0_latch = 0; r0_continue = 0;
    r0_req = 0;
    tick();
    checks++; if (dut.state_q !== StDrain) begin errors++; $display("FAIL single_drain: got %0d want 3", dut.state_q); end
    checks++; if (r0_grant !== 1'b0) begin errors++; $display("FAIL single_release: got %b want 0", r0_grant); end
    repeat (4) tick();
    checks++; if (dut.state_q !== StIdle) begin errors++; $display("FAIL single_idle: got %0d want 0", dut.state_q); end
  endtask

  task automatic test_round_robin();
    int lat;
    bit leak;
    do_reset();
    r0_req = 1; r1_req = 1; r0_wren = 1; r1_wren = 1;
    tick();
    checks++; if ({r0_grant, r1_grant} !== 2'b10) begin
      errors++; $display("FAIL tie_first: got %b want 10", {r0_grant, r1_grant});
    end
    tick();
    r0_req = 0;
    lat = 0;
    leak = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (r1_grant === 1'b1) begin
        lat = i;
        break;
      end
      if (f_wren !== 1'b0 || r0_grant !== 1'b0) leak = 1;
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL tie_latency: got %0d want 6", lat); end
    checks++; if (leak) begin errors++; $display("FAIL tie_drain_wren: got leak want none"); end
    checks++; if (f_wren !== 1'b1) begin errors++; $display("FAIL tie_r1_wren: got %b want 1", f_wren); end
    r1_req = 0;
    repeat (6) tick();
  endtask

  task automatic test_timeout();
    int cnt;
    bit regrant;
    do_reset();
    r1_req = 1;
    tick();
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (r1_grant !== 1'b1) break;
      cnt++;
      tick();
    end
    checks++; if (cnt != 101) begin errors++; $display("FAIL to_grant_cycles: got %0d want 101", cnt); end
    checks++; if (timeout_pulse !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", timeout_pulse); end
    tick();
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b want 0", timeout_pulse); end
    regrant = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (r1_grant !== 1'b0) regrant = 1;
    end
    checks++; if (regrant) begin errors++; $display("FAIL to_blocked: got regrant want none"); end
    r1_req = 0;
    tick();
    r1_req = 1;
    tick();
    checks++; if (r1_grant !== 1'b1) begin errors++; $display("FAIL to_regrant: got %b want 1", r1_grant); end
    r1_req = 0;
    repeat (6) tick();
  endtask

  task automatic test_keepalive();
    int cnt;
    do_reset();
    r0_req = 1;
    tick();
    repeat (59) tick();
    r0_latch = 1;
    #1;
    checks++; if (f_latch !== 1'b1) begin errors++; $display("FAIL ka_latch: got %b want 1", f_latch); end
    tick();
    r0_latch = 0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (r0_grant !== 1'b1) break;
      if (timeout_pulse !== 1'b0) break;
      cnt++;
      tick();
    end
    checks++; if (cnt != 101) begin errors++; $display("FAIL ka_cycles: got %0d want 101", cnt); end
    checks++; if (timeout_pulse !== 1'b1) begin errors++; $display("FAIL ka_pulse: got %b want 1", timeout_pulse); end
    r0_req = 0;
    repeat (6) tick();
  endtask

  task automatic test_drain_ready();
    bit left;
    do_reset();
    r0_req = 1; r0_wren = 1;
    tick();
    r0_req = 0; f_ready = 0;
    tick();
    left = 0;
    for (int i = 0; i < 20; i++) begin
      if (dut.state_q !== StDrain || f_wren !== 1'b0) left = 1;
      tick();
    end
    checks++; if (left) begin errors++; $display("FAIL drain_hold: got exit want stay"); end
    checks++; if (dut.state_q !== StDrain) begin errors++; $display("FAIL drain_still: got %0d want 3", dut.state_q); end
    f_ready = 1;
    tick();
    checks++; if (dut.state_q !== StIdle) begin errors++; $display("FAIL drain_exit: got %0d want 0", dut.state_q); end
  endtask

  task automatic test_modes();
    do_reset();
    r0_req = 1; r0_wren = 1; r0_rden = 1;
    tick();
    checks++; if ({f_wren, f_rden} !== 2'b10) begin
      errors++; $display("FAIL mode_both: got %b want 10", {f_wren, f_rden});
    end
    r0_wren = 0;
    #1;
    checks++; if ({f_wren, f_rden} !== 2'b01) begin
      errors++; $display("FAIL mode_read: got %b want 01", {f_wren, f_rden});
    end
    r0_req = 0; r0_rden = 0;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    r1_req = 1; r1_wren = 1;
    tick();
    r1_latch = 1; r1_data = 8'h3C;
    #1;
    checks++; if ({r1_grant, f_latch, f_data} !== {2'b11, 8'h3C}) begin
      errors++; $display("FAIL mid_pre: got %b%b %h want 11 3c", r1_grant, f_latch, f_data);
    end
    rst = 1;
    tick();
    checks++; if ({r0_grant, r1_grant, f_wren, f_rden, f_latch, r1_ready, timeout_pulse} !== 7'b0) begin
      errors++; $display("FAIL mid_outputs: got %b want 0000000",
                         {r0_grant, r1_grant, f_wren, f_rden, f_latch, r1_ready, timeout_pulse});
    end
    checks++; if (f_data !== 8'h00) begin errors++; $display("FAIL mid_fdata: got %h want 00", f_data); end
    checks++; if (dut.state_q !== StIdle) begin errors++; $display("FAIL mid_state: got %0d want 0", dut.state_q); end
    rst = 0;
    r1_latch = 0;
    r0_req = 1;
    tick();
    checks++; if ({r0_grant, r1_grant} !== 2'b10) begin
      errors++; $display("FAIL mid_tie: got %b want 10", {r0_grant, r1_grant});
    end
    clear_inputs();
    repeat (6) tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_timeout();
    test_keepalive();
    test_drain_ready();
    test_modes();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_access_arbiter.md
FLASH_ACCESS_ARBITER -- requirements
Module: flash_access_arbiter

Interface
REQ-001 Parameter SWITCH_GAP, default 4: minimum cycles f_wren/f_rden are held low between grants.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: cycles a grant may go without an accepted latch before forced revocation.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Ports r0_req / r1_req  input  1  requester wants the flash (r0 = playback/record controller, r1 = host maintenance port).
REQ-006 Ports rN_wren, rN_rden  input  1  requester's write/read mode.
REQ-007 Ports rN_data  input  8  byte for the flash.
REQ-008 Ports rN_latch, rN_continue  input  1  byte strobe and continue flag.
REQ-009 Ports rN_grant  output  1  requester owns the flash.
REQ-010 Ports rN_ready  output  1  gated flash ready.
REQ-011 Ports f_data  output  8  byte to the flash engine.
REQ-012 Ports f_latch, f_continue, f_wren, f_rden  output  1  flash engine controls.
REQ-013 Port f_ready  input  1  flash engine ready.
REQ-014 Port timeout_pulse  output  1  one-cycle flag on forced revocation.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT0, GRANT1, DRAIN, encoded in 2 bits.
REQ-016 IDLE SHALL move to GRANTn on a sole eligible rN_req and SHALL pick round-robin when both are eligible: the requester not granted last wins; last_grant resets to 1, so r0 wins the first tie.
REQ-017 rN_grant SHALL be registered, asserted only in GRANTn, and r0_grant and r1_grant SHALL never be high together.
REQ-018 In GRANTn, f_data, f_continue, f_wren SHALL be combinational copies of the granted rN_* inputs, and f_rden SHALL equal rN_rden & ~rN_wren.
REQ-019 In GRANTn, f_latch SHALL equal rN_latch & f_ready, rN_ready SHALL equal f_ready, and the other requester's ready SHALL be 0.
REQ-020 Outside GRANTn, all f_* outputs and both rN_ready SHALL be 0, and rN_latch SHALL be ignored.
REQ-021 GRANTn SHALL move to DRAIN in the cycle after rN_req is sampled low.
REQ-022 A 17-bit idle counter SHALL clear on entering GRANTn and on every accepted f_latch, and SHALL otherwise increment.
REQ-023 When the idle counter equals TIMEOUT_CYCLES, the FSM SHALL revoke the grant, move to DRAIN, pulse timeout_pulse for one cycle, and set blockN.
REQ-024 blockN SHALL make requester N ineligible until rN_req is sampled low, then SHALL clear.
REQ-025 DRAIN SHALL hold f_wren = f_rden = 0 for at least SWITCH_GAP cycles, and SHALL return to IDLE only after the gap counter expires and f_ready = 1.
REQ-026 Minimum release-to-next-grant latency SHALL be SWITCH_GAP + 2 cycles.
REQ-027 A request deasserted and reasserted during DRAIN SHALL be arbitrated normally in IDLE.
REQ-028 Counters SHALL saturate, never wrap.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE and last_grant to 1.
REQ-030 On rst, both grants, all f_* outputs, both rN_ready, and timeout_pulse SHALL be 0.
REQ-031 On rst, both counters and both block flags SHALL clear.
REQ-032 Reset asserted during GRANTn SHALL drop f_wren/f_rden in the next cycle, with no DRAIN, and the flash engine's own rst SHALL close the transaction.

Structure
REQ-033 State encoding and default SWITCH_GAP/TIMEOUT_CYCLES values SHALL live in shared package flash_arb_pkg.
REQ-034 The round-robin pick plus last_grant SHALL be one sub-module, flash_arb_rr; all other logic SHALL stay flat.

Verification
REQ-035 Bench SHALL cover r0_req alone, f_ready=1: r0_grant at cycle 2; r0 latch 0xA5 gives f_latch=1 and f_data=0xA5 the same cycle.
REQ-036 Bench SHALL cover r0_req and r1_req rising together after reset: r0 granted; r0 releases; r1_grant exactly SWITCH_GAP+2=6 cycles later; f_wren=0 throughout DRAIN.
REQ-037 Bench SHALL cover an r1 grant with no latch for TIMEOUT_CYCLES=100: timeout_pulse one cycle at idle count 100; r1 not re-granted while r1_req stays high; re-granted after one low cycle and reassert.
REQ-038 Bench SHALL cover f_ready held low in DRAIN for 20 cycles: FSM stays in DRAIN; IDLE the cycle after f_ready rises.
REQ-039 Bench SHALL cover r0 driving wren=1 and rden=1: f_wren=1, f_rden=0.
REQ-040 Bench SHALL cover rst mid-GRANT1 while latching: next cycle all outputs 0, state IDLE, and a subsequent tie granted to r0.
